mar_bus_arbiter: RTL and testbench
==================================

MAR_BUS_ARBITER -- requirements
Module: mar_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, MAR/address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 8, maximum ACCESS cycles to wait for mem_rdy (legal range 1..255).
REQ-004 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request, level.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  fetch done, one-cycle pulse.
- dt_req  in  1  data request, level.
- dt_we  in  1  data write (1) / read (0).
- dt_addr  in  ADDR_W  data address.
- dt_wdata  in  DATA_W  write data.
- dt_ack  out  1  data done, one-cycle pulse.
- rdata  out  DATA_W  last read data.
- err  out  1  timeout flag, valid with ack.
- IMR  out  1  MAR load enable, active-low.
- mar_addr  out  ADDR_W  address to MAR input.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_rdy  in  1  memory completion.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement FSM IDLE -> LOAD -> ACCESS -> RESP -> IDLE; all outputs registered.
REQ-006 IDLE: no request -> stay. One request -> grant it. Both requests -> grant the requester not granted last (round-robin bit last_gnt).
REQ-007 On grant SHALL latch the granted address, and for data also dt_we and dt_wdata; later input changes SHALL be ignored until the next IDLE.
REQ-008 LOAD SHALL last exactly one cycle with IMR=0 and mar_addr = latched address. IMR SHALL be 1 in every other state.
REQ-009 mar_addr SHALL hold its value after LOAD until the next LOAD.
REQ-010 ACCESS SHALL assert mem_rd (read or fetch) or mem_wr (data write), never both. mem_wdata = latched wdata while mem_wr=1.
REQ-011 ACCESS SHALL sample mem_rdy each cycle; on mem_rdy=1 go to RESP, and for a read latch mem_rdata into rdata on that edge.
REQ-012 An 8-bit wait counter SHALL clear on ACCESS entry. If TIMEOUT ACCESS cycles elapse without mem_rdy, go to RESP with err=1 and rdata unchanged.
REQ-013 RESP SHALL last one cycle. It pulses the granted requester's ack, drives err (0 on success), deasserts mem_rd/mem_wr and updates last_gnt.
REQ-014 err SHALL be valid only in RESP and 0 elsewhere.
REQ-015 Minimum latency with mem_rdy tied high: request seen in IDLE at cycle 0; IMR=0 at cycle 1; strobe at cycle 2; ack at cycle 3; IDLE at cycle 4.
REQ-016 Requester deasserting req after grant SHALL NOT abort the transaction; ack still pulses.
REQ-017 The requester SHALL drop req in the cycle after its ack; req still high in IDLE is treated as a new request.
REQ-018 mem_rdy outside ACCESS SHALL be ignored.

Reset
REQ-019 rst=1 at a rising edge SHALL force state IDLE, IMR=1, mar_addr=0, mem_rd=mem_wr=0, mem_wdata=0, if_ack=dt_ack=0, rdata=0, err=0, busy=0, wait counter=0, last_gnt=data (so fetch wins the first tie).
REQ-020 Reset in LOAD/ACCESS/RESP SHALL abort the transaction with no ack, effective that edge. rst has priority over all inputs.

Verification
REQ-021 Fetch, mem_rdy=1, if_addr=4'h5, mem_rdata=8'hA3 -> IMR=0 one cycle with mar_addr=5; mem_rd at cycle 2; if_ack and rdata=A3 at cycle 3; err=0.
REQ-022 Data write dt_addr=4'h6, dt_wdata=8'h5C, mem_rdy after 2 wait cycles -> mem_wr=1 for 3 cycles with mem_wdata=5C, mem_rd=0; dt_ack one cycle later.
REQ-023 if_req and dt_req both held high from reset -> grants alternate fetch, data, fetch, data; each ack 5 cycles apart.
REQ-024 Read with mem_rdy=0, TIMEOUT=8 -> mem_rd high exactly 8 cycles, then ack with err=1, rdata unchanged.
REQ-025 rst pulsed during ACCESS -> next cycle all outputs at reset values, no ack; a subsequent fetch completes normally.
REQ-026 dt_addr changed to 4'hF during ACCESS, req dropped after LOAD -> mar_addr stays at latched value, dt_ack still pulses.

Source files
------------

// File: rtl/mar_bus_arbiter.sv
// rtl/mar_bus_arbiter.sv - round-robin fetch/data arbiter driving MAR load and memory strobes
// IDLE -> LOAD -> ACCESS -> RESP; every output is a register decoded from the next state.
module mar_bus_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              dt_req,
  input  logic              dt_we,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic [DATA_W-1:0] dt_wdata,
  output logic              dt_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              IMR,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ACCESS, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state, nxt;
  logic              pick_data;
  logic              timed_out;
  logic              last_gnt;
  logic              gnt_data;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // last_gnt = 1 means data was served last, so a tie goes to fetch
  always_comb begin
    pick_data = dt_req && (!if_req || !last_gnt);
    timed_out = (wait_cnt == WAIT_LAST);
    nxt       = state;
    case (state)
      IDLE:    if (if_req || dt_req) nxt = LOAD;
      LOAD:    nxt = ACCESS;
      ACCESS:  if (mem_rdy || timed_out) nxt = RESP;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      IMR       <= 1'b1;
      mar_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dt_ack    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      wait_cnt  <= '0;
      last_gnt  <= 1'b1;
      gnt_data  <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      if (state == IDLE && nxt == LOAD) begin
        gnt_data <= pick_data;
        we_q     <= pick_data && dt_we;
        wdata_q  <= pick_data ? dt_wdata : '0;
        mar_addr <= pick_data ? dt_addr : if_addr;
      end
      IMR       <= (nxt != LOAD);
      mem_rd    <= (nxt == ACCESS) && !we_q;
      mem_wr    <= (nxt == ACCESS) && we_q;
      mem_wdata <= (nxt == ACCESS && we_q) ? wdata_q : '0;
      wait_cnt  <= (state == ACCESS && nxt == ACCESS) ? wait_cnt + 8'd1 : 8'd0;
      if (state == ACCESS && mem_rdy && !we_q) rdata <= mem_rdata;
      err       <= (state == ACCESS) && (nxt == RESP) && !mem_rdy;
      if_ack    <= (state == ACCESS) && (nxt == RESP) && !gnt_data;
      dt_ack    <= (state == ACCESS) && (nxt == RESP) && gnt_data;
      busy      <= (nxt != IDLE);
      if (state == RESP) last_gnt <= gnt_data;
    end
  end

endmodule

// File: tb/tb_mar_bus_arbiter.sv
// tb/tb_mar_bus_arbiter.sv - scoreboard bench for mar_bus_arbiter
// Stimulus pushes expected transactions; a negedge monitor pops them on each ack.
module tb_mar_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       if_req, dt_req, dt_we;
  logic [3:0] if_addr, dt_addr;
  logic [7:0] dt_wdata, mem_rdata;
  logic       if_ack, dt_ack, err, IMR, mem_rd, mem_wr, busy, mem_rdy;
  logic [7:0] rdata, mem_wdata;
  logic [3:0] mar_addr;

  logic       rdy_tie = 1'b0;
  int         wait_n = 0;
  int         scnt = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    bit         is_data;
    bit         err;
    logic [7:0] rdata;
    logic [3:0] addr;
    int         nrd;
    int         nwr;
    logic [7:0] wdata;
    int         gap;
    int         l2a;
  } exp_t;
  exp_t q[$];

  mar_bus_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
    .dt_ack(dt_ack), .rdata(rdata), .err(err), .IMR(IMR), .mar_addr(mar_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rdy(mem_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory model: ready after wait_n strobe cycles, or tied high
  assign mem_rdy = rdy_tie || ((mem_rd || mem_wr) && (scnt >= wait_n));
  always @(posedge clk) begin
    scnt <= (mem_rd || mem_wr) ? scnt + 1 : 0;
    cyc  <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(bit d, bit e, logic [7:0] rd, logic [3:0] a, int nrd, int nwr,
                              logic [7:0] wd, int gap, int l2a);
    exp_t x;
    x.is_data = d; x.err = e; x.rdata = rd; x.addr = a; x.nrd = nrd; x.nwr = nwr;
    x.wdata = wd; x.gap = gap; x.l2a = l2a;
    return x;
  endfunction

  int         load_cyc = 0, last_ack = 0, nrd = 0, nwr = 0;
  logic [7:0] seen_wdata = 8'h0;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      nrd = 0; nwr = 0;
    end else begin
      if (!IMR) begin
        load_cyc = cyc; nrd = 0; nwr = 0; seen_wdata = 8'h0;
      end
      if (mem_rd) nrd++;
      if (mem_wr) begin nwr++; seen_wdata = mem_wdata; end
      if (err && !(if_ack || dt_ack)) begin
        errors++;
        $display("FAIL err_outside_resp: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (if_ack || dt_ack) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got if_ack=%0b dt_ack=%0b expected none (cycle %0d)",
                   if_ack, dt_ack, cyc);
        end else begin
          e = q.pop_front();
          check("ack_kind", {31'd0, dt_ack}, {31'd0, e.is_data});
          check("ack_both", {31'd0, if_ack & dt_ack}, 0);
          check("err", {31'd0, err}, {31'd0, e.err});
          check("rdata", {24'd0, rdata}, {24'd0, e.rdata});
          check("mar_addr", {28'd0, mar_addr}, {28'd0, e.addr});
          check("rd_cycles", nrd, e.nrd);
          check("wr_cycles", nwr, e.nwr);
          if (e.nwr > 0) check("mem_wdata", {24'd0, seen_wdata}, {24'd0, e.wdata});
          check("load_to_ack", cyc - load_cyc, e.l2a);
          if (e.gap > 0) check("ack_gap", cyc - last_ack, e.gap);
        end
        last_ack = cyc;
      end
    end
  end

  task automatic check_reset();
    check("rst_IMR", {31'd0, IMR}, 1);
    check("rst_mar_addr", {28'd0, mar_addr}, 0);
    check("rst_mem_rd", {31'd0, mem_rd}, 0);
    check("rst_mem_wr", {31'd0, mem_wr}, 0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 0);
    check("rst_acks", {30'd0, if_ack, dt_ack}, 0);
    check("rst_rdata", {24'd0, rdata}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
  endtask

  // raise a request, wait for LOAD, then drop it and scramble the inputs
  task automatic issue(input bit d, input bit we, input logic [3:0] a, input logic [7:0] wd);
    bit seen = 0;
    @(posedge clk); #1;
    if (d) begin dt_req = 1; dt_we = we; dt_addr = a; dt_wdata = wd; end
    else begin if_req = 1; if_addr = a; end
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (!IMR) seen = 1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL load_timeout: got no IMR pulse expected one within 20 cycles");
    end
    @(posedge clk); #1;
    if_req = 0; dt_req = 0; if_addr = 4'hF; dt_addr = 4'hF; dt_wdata = 8'hFF; dt_we = ~dt_we;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    if_req = 0; dt_req = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; if_req = 0; dt_req = 0; dt_we = 0; if_addr = 0; dt_addr = 0;
    dt_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    rst = 0;

    // cycle-exact fetch with mem_rdy tied high
    rdy_tie = 1; mem_rdata = 8'hA3;
    q.push_back(mk(0, 0, 8'hA3, 4'h5, 1, 0, 8'h00, 0, 2));
    @(posedge clk); #1;
    if_addr = 4'h5; if_req = 1;
    @(negedge clk);
    check("c0_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
    if_req = 0;
    @(negedge clk);
    check("c1_IMR", {31'd0, IMR}, 0);
    check("c1_mar", {28'd0, mar_addr}, 5);
    @(negedge clk);
    check("c2_mem_rd", {30'd0, mem_rd, mem_wr}, 2);
    check("c2_IMR", {31'd0, IMR}, 1);
    @(negedge clk);
    check("c3_if_ack", {31'd0, if_ack}, 1);
    @(negedge clk);
    check("c4_idle", {30'd0, busy, if_ack}, 0);
    drain();

    // write with two wait cycles
    rdy_tie = 0; wait_n = 2;
    q.push_back(mk(1, 0, 8'hA3, 4'h6, 0, 3, 8'h5C, 0, 4));
    issue(1, 1, 4'h6, 8'h5C);
    drain();

    // read that times out
    wait_n = 255; mem_rdata = 8'h77;
    q.push_back(mk(1, 1, 8'hA3, 4'h3, 8, 0, 8'h00, 0, 9));
    issue(1, 0, 4'h3, 8'h00);
    drain();

    // successful data read, no wait
    wait_n = 0; mem_rdata = 8'h3C;
    q.push_back(mk(1, 0, 8'h3C, 4'h9, 1, 0, 8'h00, 0, 2));
    issue(1, 0, 4'h9, 8'h00);
    drain();

    // write whose inputs change after LOAD
    wait_n = 3;
    q.push_back(mk(1, 0, 8'h3C, 4'h2, 0, 4, 8'h11, 0, 5));
    issue(1, 1, 4'h2, 8'h11);
    drain();

    // reset during ACCESS aborts without ack
    wait_n = 255;
    issue(0, 0, 4'h7, 8'h00);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check_reset();
    rst = 0;
    repeat (12) @(posedge clk);
    #1;
    check("post_abort_busy", {31'd0, busy}, 0);
    rdy_tie = 1; mem_rdata = 8'h5A;
    q.push_back(mk(0, 0, 8'h5A, 4'h8, 1, 0, 8'h00, 0, 2));
    issue(0, 0, 4'h8, 8'h00);
    drain();

    // both requesters held from reset: fetch wins first, then alternate
    rdy_tie = 0; wait_n = 1; mem_rdata = 8'h42;
    rst = 1;
    if_addr = 4'h1; dt_addr = 4'hA; dt_we = 1; dt_wdata = 8'hE7;
    if_req = 1; dt_req = 1;
    q.push_back(mk(0, 0, 8'h42, 4'h1, 2, 0, 8'h00, 0, 3));
    q.push_back(mk(1, 0, 8'h42, 4'hA, 0, 2, 8'hE7, 5, 3));
    q.push_back(mk(0, 0, 8'h42, 4'h1, 2, 0, 8'h00, 5, 3));
    q.push_back(mk(1, 0, 8'h42, 4'hA, 0, 2, 8'hE7, 5, 3));
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
